// File: rtl/result_collector.sv
// Deskews the per-column result stream from the bottom of the systolic array
// into an N x N buffer, then drains it one row per valid/ready transfer.
module result_collector #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [MATRIX_SIZE-1:0]                        col_valid,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0]              col_data,
  input  logic                                          done,
  input  logic                                          out_ready,
  output logic                                          out_valid,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0]              out_data,
  output logic [(MATRIX_SIZE>1?$clog2(MATRIX_SIZE):1)-1:0] out_row,
  output logic                                          busy,
  output logic                                          overflow
);
  localparam int RW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam int CW = $clog2(MATRIX_SIZE + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(MATRIX_SIZE - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL, DRAIN} state_t;

  state_t                 state_reg, state_next;
  logic [RW-1:0]          rd_ptr_reg, rd_ptr_next;
  logic                   overflow_reg;
  logic [MATRIX_SIZE-1:0] cap;
  logic [MATRIX_SIZE-1:0] cnt_full;
  logic                   accepting;
  logic                   load_row;
  logic                   clear_cnt;

  assign accepting = (state_reg == IDLE) || (state_reg == COLLECT);

  // Each column owns its own write counter and storage column, so skew between
  // columns never needs cross-column coordination.
  genvar gi;
  generate
    for (gi = 0; gi < MATRIX_SIZE; gi++) begin : g_col
      logic [CW-1:0]        wr_cnt_reg;
      logic [DATA_SIZE-1:0] col_mem [MATRIX_SIZE];
      logic [DATA_SIZE-1:0] row_word_reg;

      assign cap[gi]      = col_valid[gi] && accepting && (wr_cnt_reg != CW'(MATRIX_SIZE));
      assign cnt_full[gi] = (wr_cnt_reg + CW'(cap[gi])) == CW'(MATRIX_SIZE);

      always_ff @(posedge clk) begin
        if (reset || clear_cnt) begin
          wr_cnt_reg <= '0;
        end else if (cap[gi]) begin
          wr_cnt_reg <= wr_cnt_reg + 1'b1;
        end
      end

      // Buffer contents survive reset; only counters decide what is valid.
      always_ff @(posedge clk) begin
        if (cap[gi]) begin
          col_mem[wr_cnt_reg[RW-1:0]] <= col_data[gi*DATA_SIZE +: DATA_SIZE];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          row_word_reg <= '0;
        end else if (load_row) begin
          row_word_reg <= col_mem[rd_ptr_next];
        end
      end

      assign out_data[gi*DATA_SIZE +: DATA_SIZE] = row_word_reg;
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    rd_ptr_next = rd_ptr_reg;
    load_row    = 1'b0;
    clear_cnt   = 1'b0;
    case (state_reg)
      IDLE:    if (|cap) state_next = (&cnt_full) ? FULL : COLLECT;
      COLLECT: if (&cnt_full) state_next = FULL;
      FULL: begin
        if (done) begin
          state_next  = DRAIN;
          rd_ptr_next = '0;
          load_row    = 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rd_ptr_reg == LAST_ROW) begin
            state_next  = IDLE;
            rd_ptr_next = '0;
            clear_cnt   = 1'b1;
          end else begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
            load_row    = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_ptr_reg   <= rd_ptr_next;
      // Any pulse not captured (column already full, or not collecting) is lost.
      overflow_reg <= overflow_reg | (|(col_valid & ~cap));
    end
  end

  assign out_valid = (state_reg == DRAIN);
  assign out_row   = rd_ptr_reg;
  assign busy      = (state_reg != IDLE);
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector (N=2): expected rows are queued when a
// matrix is streamed in and compared as the collector drains them.
module tb_result_collector;
  localparam int N  = 2;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    col_valid;
  logic [N*DW-1:0] col_data;
  logic            done;
  logic            out_ready;
  logic            out_valid;
  logic [N*DW-1:0] out_data;
  logic [0:0]      out_row;
  logic            busy;
  logic            overflow;

  typedef struct packed {
    logic [0:0]      row;
    logic [N*DW-1:0] data;
  } exp_row_t;

  exp_row_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  result_collector #(.MATRIX_SIZE(N), .DATA_SIZE(DW)) dut (
    .clk(clk), .reset(reset), .col_valid(col_valid), .col_data(col_data),
    .done(done), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_row(out_row), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] cv, input logic [DW-1:0] d1, input logic [DW-1:0] d0);
    col_valid = cv;
    col_data  = {d1, d0};
    step();
    col_valid = '0;
  endtask

  // Column 0 leads column 1 by one cycle; rows queued as {c1, c0}.
  task automatic load_matrix(input logic [DW-1:0] a00, input logic [DW-1:0] a01,
                             input logic [DW-1:0] a10, input logic [DW-1:0] a11);
    exp_q.push_back('{row: 1'b0, data: {a01, a00}});
    exp_q.push_back('{row: 1'b1, data: {a11, a10}});
    drive(2'b01, 32'd0, a00);
    drive(2'b11, a01, a10);
    drive(2'b10, a11, 32'd0);
  endtask

  task automatic drain_rows(input int n);
    exp_row_t e;
    for (int i = 0; i < n; i++) begin
      for (int t = 0; t < 20 && !out_valid; t++) step();
      check("out_valid", {63'd0, out_valid}, 64'd1);
      if (exp_q.size() == 0) begin
        check("queue_nonempty", 64'd0, 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("out_row", {63'd0, out_row}, {63'd0, e.row});
        check("out_data", out_data, e.data);
        $display("row %0d: data %h expected %h", out_row, out_data, e.data);
      end
      out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    check("busy_after_drain", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    exp_row_t head;
    reset = 1'b1; col_valid = '0; col_data = '0; done = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_row", {63'd0, out_row}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);

    // Basic run: FULL after last capture, out_valid two edges later.
    done = 1'b1;
    load_matrix(32'd10, 32'd11, 32'd20, 32'd21);
    check("full_no_valid", {63'd0, out_valid}, 64'd0);
    check("full_busy", {63'd0, busy}, 64'd1);
    step();
    check("latency_valid", {63'd0, out_valid}, 64'd1);
    drain_rows(2);

    // Backpressure: row 0 held for 3 stalled cycles.
    load_matrix(32'd30, 32'd31, 32'd40, 32'd41);
    step();
    head = exp_q[0];
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      check("stall_row", {63'd0, out_row}, {63'd0, head.row});
      check("stall_data", out_data, head.data);
    end
    drain_rows(2);

    // done held low: waits in FULL.
    done = 1'b0;
    load_matrix(32'd50, 32'd51, 32'd60, 32'd61);
    for (int i = 0; i < 10; i++) begin
      step();
      check("wait_valid", {63'd0, out_valid}, 64'd0);
      check("wait_busy", {63'd0, busy}, 64'd1);
    end
    done = 1'b1;
    step();
    check("done_valid", {63'd0, out_valid}, 64'd1);
    drain_rows(2);

    // Overflow: extra pulse on column 0 while column 1 is still pending.
    exp_q.push_back('{row: 1'b0, data: {32'd2, 32'd1}});
    exp_q.push_back('{row: 1'b1, data: {32'd4, 32'd3}});
    drive(2'b11, 32'd2, 32'd1);
    drive(2'b01, 32'd0, 32'd3);
    check("ovf_before", {63'd0, overflow}, 64'd0);
    drive(2'b01, 32'd0, 32'd99);
    check("ovf_set", {63'd0, overflow}, 64'd1);
    drive(2'b10, 32'd4, 32'd0);
    drain_rows(2);
    check("ovf_sticky", {63'd0, overflow}, 64'd1);

    // Reset mid-COLLECT aborts the partial matrix.
    drive(2'b01, 32'd0, 32'd77);
    check("mid_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mrst_out_row", {63'd0, out_row}, 64'd0);
    check("mrst_out_data", out_data, 64'd0);
    check("mrst_busy", {63'd0, busy}, 64'd0);
    check("mrst_overflow", {63'd0, overflow}, 64'd0);

    // Fresh run followed back-to-back by a second matrix.
    load_matrix(32'd5, 32'd6, 32'd7, 32'd8);
    drain_rows(2);
    load_matrix(32'd100, 32'd101, 32'd102, 32'd103);
    drain_rows(2);
    check("b2b_overflow", {63'd0, overflow}, 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
